fb_mem_responder: RTL



---
 rtl/fb_mem_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_mem_responder                                              |
// | Purpose  : Memory-side responder for the framebuffer command/result      |
// |            FIFOs. Drains single (write/fill/read) and burst (8-word      |
// |            read) commands and runs them on a req/ack memory port. Read   |
// |            results go to the single-read and burst-read result FIFOs.    |
// | Ports    : clk_pix, reset_ni (async, active-low)                         |
// |            cmd_q_i/cmd_empty_i/cmd_deq_o         single command FIFO     |
// |            burst_cmd_q_i/burst_cmd_empty_i/burst_cmd_deq_o  burst FIFO   |
// |            rd_d_o/rd_enq_o/rd_full_i             single-read result      |
// |            rd_burst_d_o/rd_burst_enq_o/rd_burst_full_i  burst result     |
// |            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i/        |
// |            mem_ack_i                             memory port             |
// |            busy_o, dbg_state_o                   status                  |
// | Options  : FB_MEM_FILL_PREEMPT_EN - a pending burst may suspend a fill   |
// |            between writes; the fill resumes right after the burst.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fb_mem_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 8
) (
  input  logic                    clk_pix,
  input  logic                    reset_ni,
  input  logic [59:0]             cmd_q_i,
  input  logic                    cmd_empty_i,
  output logic                    cmd_deq_o,
  input  logic [31:0]             burst_cmd_q_i,
  input  logic                    burst_cmd_empty_i,
  output logic                    burst_cmd_deq_o,
  output logic [15:0]             rd_d_o,
  output logic                    rd_enq_o,
  input  logic                    rd_full_i,
  output logic [16*BURST_LEN-1:0] rd_burst_d_o,
  output logic                    rd_burst_enq_o,
  input  logic                    rd_burst_full_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [15:0]             mem_wdata_o,
  input  logic [15:0]             mem_rdata_i,
  input  logic                    mem_ack_i,
  output logic                    busy_o,
  output logic [3:0]              dbg_state_o
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int BURST_W = 16 * BURST_LEN;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CMD        = 4'd1,
    S_WRITE      = 4'd2,
    S_READ       = 4'd3,
    S_READ_PUSH  = 4'd4,
    S_BURST      = 4'd5,
    S_BURST_READ = 4'd6,
    S_BURST_PUSH = 4'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;     // fill/single address
  logic [ADDR_WIDTH-1:0]   baddr_q, baddr_d;   // burst address, kept apart so a suspended fill survives
  logic [19:0]             cnt_q, cnt_d;
  logic [15:0]             data_q, data_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [15:0]             rd_d_q, rd_d_d;
  logic [BURST_W-1:0]      burst_q, burst_d;
  logic                    susp_q, susp_d;
  logic                    gap_q;              // forces mem_req_o low the cycle after an ack
  logic                    w_req, w_ack, w_cmd_deq, w_burst_deq;
  logic                    w_unused_bits;

  assign w_unused_bits = ^burst_cmd_q_i[31:ADDR_WIDTH];

  assign w_req = !gap_q && (state_q == S_WRITE || state_q == S_READ || state_q == S_BURST_READ);
  assign w_ack = w_req && mem_ack_i;

  assign mem_req_o      = w_req;
  assign mem_we_o       = (state_q == S_WRITE);
  assign mem_addr_o     = (state_q == S_BURST_READ) ? baddr_q : addr_q;
  assign mem_wdata_o    = data_q;
  assign rd_d_o         = rd_d_q;
  assign rd_burst_d_o   = burst_q;
  assign busy_o         = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;
  // IDLE decodes FIFO status combinationally; keep the pulses quiet while reset is held.
  assign cmd_deq_o       = w_cmd_deq && reset_ni;
  assign burst_cmd_deq_o = w_burst_deq && reset_ni;

  always_ff @(posedge clk_pix or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      baddr_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      rd_d_q  <= '0;
      burst_q <= '0;
      susp_q  <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      baddr_q <= baddr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      rd_d_q  <= rd_d_d;
      burst_q <= burst_d;
      susp_q  <= susp_d;
      gap_q   <= w_ack;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    baddr_d        = baddr_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    beat_d         = beat_q;
    rd_d_d         = rd_d_q;
    burst_d        = burst_q;
    susp_d         = susp_q;
    w_cmd_deq      = 1'b0;
    w_burst_deq    = 1'b0;
    rd_enq_o       = 1'b0;
    rd_burst_enq_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!burst_cmd_empty_i) begin
          w_burst_deq = 1'b1;
          baddr_d     = burst_cmd_q_i[ADDR_WIDTH-1:0];
          beat_d      = '0;
          state_d     = S_BURST;
        end else if (susp_q) begin
          susp_d  = 1'b0;
          state_d = S_WRITE;
        end else if (!cmd_empty_i) begin
          w_cmd_deq = 1'b1;
          cnt_d     = cmd_q_i[59:40];
          addr_d    = cmd_q_i[16 +: ADDR_WIDTH];
          data_d    = cmd_q_i[15:0];
          state_d   = S_CMD;
        end
      end
      S_CMD: state_d = (cnt_q != 20'd0) ? S_WRITE : S_READ;
      S_WRITE: begin
        if (w_ack) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == 20'd1) begin
            state_d = S_IDLE;
          end
`ifdef FB_MEM_FILL_PREEMPT_EN
          else if (!burst_cmd_empty_i) begin
            // addr/cnt/data already hold the resume point
            susp_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_READ: begin
        if (w_ack) begin
          rd_d_d  = mem_rdata_i;
          state_d = S_READ_PUSH;
        end
      end
      S_READ_PUSH: begin
        if (!rd_full_i) begin
          rd_enq_o = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_BURST: state_d = S_BURST_READ;
      S_BURST_READ: begin
        if (w_ack) begin
          // shift left so the first word ends up in the top slot
          burst_d = {burst_q[BURST_W-17:0], mem_rdata_i};
          baddr_d = baddr_q + 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = S_BURST_PUSH;
          end
        end
      end
      S_BURST_PUSH: begin
        if (!rd_burst_full_i) begin
          rd_burst_enq_o = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
